// File: rtl/skid_pipeline_if.sv
// rtl/skid_pipeline_if.sv - valid/ready bundle for skid_pipeline (upstream, downstream, flush, occupancy)
interface skid_pipeline_if #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2
);
    localparam int OCC_W = $clog2(2 * STAGES + 1);

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  flush;
    logic [OCC_W-1:0]      occupancy;

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        input  flush,
        output in_ready,
        output out_data,
        output out_valid,
        output occupancy
    );

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        output flush,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  occupancy
    );
endinterface

// File: rtl/skid_pipeline.sv
// rtl/skid_pipeline.sv - chain of two-entry skid stages; every ready and valid comes straight from a flop
// Synchronous flush empties all stages; occupancy tracks words held across the chain.
module skid_pipeline #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    skid_pipeline_if.slave bus
);
    localparam int OCC_W = $clog2(2 * STAGES + 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    logic [STAGES-1:0]     w_mv;
    logic [STAGES-1:0]     w_ready_up;
    logic [DATA_WIDTH-1:0] w_m_data [STAGES];

    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic [OCC_W-1:0]      r_occ;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        stage_state_t          r_state;
        stage_state_t          w_state_nxt;
        logic [DATA_WIDTH-1:0] r_m;
        logic [DATA_WIDTH-1:0] r_s;
        logic                  w_up_valid;
        logic [DATA_WIDTH-1:0] w_up_data;
        logic                  w_down_ready;
        logic                  w_accept;
        logic                  w_drain;
        logic                  w_load_m_up;
        logic                  w_load_m_s;
        logic                  w_load_s;

        if (g == 0) begin : g_head
            assign w_up_valid = bus.in_valid;
            assign w_up_data  = bus.in_data;
        end else begin : g_link
            assign w_up_valid = w_mv[g-1];
            assign w_up_data  = w_m_data[g-1];
        end

        if (g == STAGES - 1) begin : g_tail
            assign w_down_ready = bus.out_ready;
        end else begin : g_inner
            assign w_down_ready = w_ready_up[g+1];
        end

        // Both sides of an inter-stage hop evaluate the same mv/!sv pair, so they always agree.
        assign w_accept = w_up_valid && (r_state != ST_FULL);
        assign w_drain  = (r_state != ST_EMPTY) && w_down_ready;

        always_comb begin
            w_state_nxt = r_state;
            w_load_m_up = 1'b0;
            w_load_m_s  = 1'b0;
            w_load_s    = 1'b0;
            if (bus.flush) begin
                w_state_nxt = ST_EMPTY;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_accept) begin
                            w_state_nxt = ST_BUSY;
                            w_load_m_up = 1'b1;
                        end
                    end
                    ST_BUSY: begin
                        if (w_accept && !w_drain) begin
                            w_state_nxt = ST_FULL;
                            w_load_s    = 1'b1;
                        end else if (w_drain && !w_accept) begin
                            w_state_nxt = ST_EMPTY;
                        end else if (w_accept && w_drain) begin
                            w_load_m_up = 1'b1;
                        end
                    end
                    ST_FULL: begin
                        if (w_drain) begin
                            w_state_nxt = ST_BUSY;
                            w_load_m_s  = 1'b1;
                        end
                    end
                    default: w_state_nxt = ST_EMPTY;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_EMPTY;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_m <= '0;
                r_s <= '0;
            end else begin
                if (w_load_m_up) begin
                    r_m <= w_up_data;
                end else if (w_load_m_s) begin
                    r_m <= r_s;
                end
                if (w_load_s) begin
                    r_s <= w_up_data;
                end
            end
        end

        assign w_mv[g]       = (r_state != ST_EMPTY);
        assign w_ready_up[g] = (r_state != ST_FULL);
        assign w_m_data[g]   = r_m;
    end

    assign w_in_xfer  = bus.in_valid && w_ready_up[0];
    assign w_out_xfer = w_mv[STAGES-1] && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (bus.flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_in_xfer) - OCC_W'(w_out_xfer);
        end
    end

    assign bus.in_ready  = w_ready_up[0];
    assign bus.out_valid = w_mv[STAGES-1];
    assign bus.out_data  = w_m_data[STAGES-1];
    assign bus.occupancy = r_occ;
endmodule

// File: tb/tb_skid_pipeline.sv
// tb/tb_skid_pipeline.sv - directed and randomised checks of skid_pipeline at STAGES 1, 2 and 4
module tb_skid_pipeline;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    skid_pipeline_if #(.DATA_WIDTH(DW), .STAGES(2)) bus2 ();
    skid_pipeline_if #(.DATA_WIDTH(DW), .STAGES(1)) bus1 ();
    skid_pipeline_if #(.DATA_WIDTH(DW), .STAGES(4)) bus4 ();

    skid_pipeline #(.DATA_WIDTH(DW), .STAGES(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    skid_pipeline #(.DATA_WIDTH(DW), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    skid_pipeline #(.DATA_WIDTH(DW), .STAGES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    task automatic drive(input int n, input logic iv, input logic [DW-1:0] d, input logic ordy);
        case (n)
            0: begin bus1.in_valid = iv; bus1.in_data = d; bus1.out_ready = ordy; end
            1: begin bus2.in_valid = iv; bus2.in_data = d; bus2.out_ready = ordy; end
            default: begin bus4.in_valid = iv; bus4.in_data = d; bus4.out_ready = ordy; end
        endcase
    endtask

    task automatic sample(input int n, output logic ir, output logic ov, output logic [DW-1:0] od,
                          output int occ);
        case (n)
            0: begin ir = bus1.in_ready; ov = bus1.out_valid; od = bus1.out_data; occ = int'(bus1.occupancy); end
            1: begin ir = bus2.in_ready; ov = bus2.out_valid; od = bus2.out_data; occ = int'(bus2.occupancy); end
            default: begin ir = bus4.in_ready; ov = bus4.out_valid; od = bus4.out_data; occ = int'(bus4.occupancy); end
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", bus2.out_valid); end
        checks++; if (bus2.out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got %h want 0", bus2.out_data); end
        checks++; if (bus2.occupancy !== 3'd0) begin failures++; $display("FAIL reset_occupancy got %0d want 0", bus2.occupancy); end
        checks++; if (bus2.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", bus2.in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_word();
        @(negedge clk);
        bus2.in_valid = 1'b1; bus2.in_data = 32'hA5A5A5A5; bus2.out_ready = 1'b1; bus2.flush = 1'b0;
        checks++; if (bus2.in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got %b want 1", bus2.in_ready); end
        @(negedge clk);
        bus2.in_valid = 1'b0;
        checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got %b want 0", bus2.out_valid); end
        checks++; if (bus2.occupancy !== 3'd1) begin failures++; $display("FAIL single_occ_a got %0d want 1", bus2.occupancy); end
        @(negedge clk);
        checks++; if (bus2.out_valid !== 1'b1 || bus2.out_data !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL single_out got v=%b d=%h want v=1 d=a5a5a5a5", bus2.out_valid, bus2.out_data);
        end
        checks++; if (bus2.occupancy !== 3'd1) begin failures++; $display("FAIL single_occ_b got %0d want 1", bus2.occupancy); end
        @(negedge clk);
        checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL single_drained got %b want 0", bus2.out_valid); end
        checks++; if (bus2.occupancy !== 3'd0) begin failures++; $display("FAIL single_occ_c got %0d want 0", bus2.occupancy); end
    endtask

    task automatic test_streaming();
        int first = -1;
        int last  = -1;
        int cnt   = 0;
        logic [DW-1:0] exp_word = 32'h1;
        bus2.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus2.out_valid) begin
                checks++; if (bus2.out_data !== exp_word) begin
                    failures++; $display("FAIL stream_data got %h want %h", bus2.out_data, exp_word);
                end
                exp_word++;
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
            if (c < 8) begin
                checks++; if (bus2.in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cyc=%0d got 0 want 1", c); end
                bus2.in_valid = 1'b1; bus2.in_data = 32'(c + 1);
            end else begin
                bus2.in_valid = 1'b0;
            end
        end
        checks++; if (cnt != 8) begin failures++; $display("FAIL stream_count got %0d want 8", cnt); end
        checks++; if (last - first != 7) begin failures++; $display("FAIL stream_bubbles span got %0d want 7", last - first); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int got = 0;
        logic [DW-1:0] exp_word = 32'h10;
        bus2.out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1; bus2.in_data = 32'h10 + 32'(acc);
            if (bus2.in_ready) acc++;
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
        checks++; if (acc != 4) begin failures++; $display("FAIL bp_accepted got %0d want 4", acc); end
        checks++; if (bus2.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got %b want 0", bus2.in_ready); end
        checks++; if (bus2.occupancy !== 3'd4) begin failures++; $display("FAIL bp_occupancy got %0d want 4", bus2.occupancy); end
        checks++; if (bus2.out_valid !== 1'b1 || bus2.out_data !== 32'h10) begin
            failures++; $display("FAIL bp_head got v=%b d=%h want v=1 d=10", bus2.out_valid, bus2.out_data);
        end
        bus2.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus2.out_valid) begin
                checks++; if (bus2.out_data !== exp_word) begin
                    failures++; $display("FAIL bp_order got %h want %h", bus2.out_data, exp_word);
                end
                exp_word++;
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != 4) begin failures++; $display("FAIL bp_drain_count got %0d want 4", got); end
        checks++; if (bus2.out_valid !== 1'b0 || bus2.occupancy !== 3'd0) begin
            failures++; $display("FAIL bp_empty got v=%b occ=%0d want v=0 occ=0", bus2.out_valid, bus2.occupancy);
        end
    endtask

    task automatic test_flush();
        logic seen = 1'b0;
        bus2.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1; bus2.in_data = 32'h20 + 32'(c);
        end
        @(negedge clk);
        checks++; if (bus2.occupancy !== 3'd3) begin failures++; $display("FAIL flush_pre_occ got %0d want 3", bus2.occupancy); end
        bus2.flush = 1'b1; bus2.in_valid = 1'b1; bus2.in_data = 32'hDEAD;
        @(negedge clk);
        bus2.flush = 1'b0; bus2.in_valid = 1'b0;
        checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got %b want 0", bus2.out_valid); end
        checks++; if (bus2.occupancy !== 3'd0) begin failures++; $display("FAIL flush_occ got %0d want 0", bus2.occupancy); end
        checks++; if (bus2.in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got %b want 1", bus2.in_ready); end
        bus2.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus2.out_valid !== 1'b0 || bus2.out_data === 32'hDEAD) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_leak got 1 want 0"); end
    endtask

    task automatic test_async_reset();
        bus2.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1; bus2.in_data = 32'h40 + 32'(c);
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
        checks++; if (bus2.occupancy !== 3'd4) begin failures++; $display("FAIL arst_pre_occ got %0d want 4", bus2.occupancy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got %b want 0", bus2.out_valid); end
        checks++; if (bus2.occupancy !== 3'd0) begin failures++; $display("FAIL arst_occ got %0d want 0", bus2.occupancy); end
        checks++; if (bus2.in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready got %b want 1", bus2.in_ready); end
        checks++; if (bus2.out_data !== 32'h0) begin failures++; $display("FAIL arst_out_data got %h want 0", bus2.out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        test_single_word();
    endtask

    task automatic test_random();
        int stg [3];
        stg[0] = 1; stg[1] = 2; stg[2] = 4;
        for (int n = 0; n < 3; n++) begin
            logic [DW-1:0] q [$];
            logic [DW-1:0] next_word;
            logic [DW-1:0] od;
            logic [DW-1:0] pod;
            logic          ir, ov, pov, pout, iv, ordy;
            int            occ, got, cyc;
            q.delete();
            next_word = 32'(n + 1) << 24;
            got = 0; cyc = 0; pov = 1'b0; pout = 1'b0; pod = '0;
            while (got < 500 && cyc < 20000) begin
                @(negedge clk);
                sample(n, ir, ov, od, occ);
                checks++; if (occ != q.size()) begin
                    failures++; $display("FAIL rand_occ stages=%0d cyc=%0d got %0d want %0d", stg[n], cyc, occ, q.size());
                end
                if (pov && !pout) begin
                    checks++; if (ov !== 1'b1 || od !== pod) begin
                        failures++; $display("FAIL rand_stall stages=%0d cyc=%0d got v=%b d=%h want v=1 d=%h", stg[n], cyc, ov, od, pod);
                    end
                end
                iv   = 1'($urandom_range(0, 1));
                ordy = 1'($urandom_range(0, 1));
                drive(n, iv, next_word, ordy);
                if (ov && ordy) begin
                    checks++; if (q.size() == 0 || od !== q[0]) begin
                        failures++; $display("FAIL rand_order stages=%0d cyc=%0d got %h want %h", stg[n], cyc, od, (q.size() == 0) ? 32'hx : q[0]);
                    end
                    if (q.size() != 0) void'(q.pop_front());
                    got++;
                end
                if (iv && ir) begin
                    q.push_back(next_word);
                    next_word++;
                end
                pov = ov; pod = od; pout = ov && ordy;
                cyc++;
            end
            checks++; if (got < 500) begin failures++; $display("FAIL rand_timeout stages=%0d got %0d want 500", stg[n], got); end
            @(negedge clk);
            drive(n, 1'b0, '0, 1'b0);
        end
    endtask

    initial begin
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0; bus2.flush = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0; bus1.flush = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0; bus4.flush = 1'b0;
        test_reset();
        test_single_word();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
